// File: rtl/div_ctrl.sv
// Sequencer between EX and the iterative 32-bit divider: resolves divide-by-zero/overflow
// locally and otherwise runs the start/annul handshake. Optional result cache: DIV_CTRL_RESULT_CACHE_EN.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              op_valid_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              result_valid_o,
  output logic [XLEN-1:0]   result_o,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [XLEN-1:0]   div_dividend_o,
  output logic [XLEN-1:0]   div_divisor_o,
  input  logic              div_ready_i,
  input  logic [2*XLEN-1:0] div_result_i
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPECIAL,
    S_WAIT,
    S_RELEASE,
    S_ABORT
  } state_t;

  state_t          state_q, state_d;

  logic            accept;
  logic            op_signed;
  logic            is_special;
  logic [XLEN-1:0] spec_q_d, spec_r_d;

  logic            sel_rem_q;
  logic            signed_q;
  logic [XLEN-1:0] dividend_q, divisor_q;
  logic [XLEN-1:0] special_q_q, special_r_q;
  logic [XLEN-1:0] result_hold_q;
  logic [XLEN-1:0] result_now;

  logic            store_div;
  logic            store_spec;

  assign accept    = (state_q == S_IDLE) && op_valid_i && !flush_i;
  assign op_signed = ~op_i[0];

`ifdef DIV_CTRL_RESULT_CACHE_EN
  logic            cache_valid_q;
  logic            cache_signed_q;
  logic [XLEN-1:0] cache_rs1_q, cache_rs2_q;
  logic [XLEN-1:0] cache_q_q, cache_r_q;
  logic            cache_hit;

  assign cache_hit = cache_valid_q && (cache_signed_q == op_signed)
                   && (cache_rs1_q == rs1_i) && (cache_rs2_q == rs2_i);

  // Flush invalidates before any same-cycle store can land.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_rs1_q    <= '0;
      cache_rs2_q    <= '0;
      cache_q_q      <= '0;
      cache_r_q      <= '0;
    end else if (flush_i) begin
      cache_valid_q  <= 1'b0;
    end else if (store_div) begin
      cache_valid_q  <= 1'b1;
      cache_signed_q <= signed_q;
      cache_rs1_q    <= dividend_q;
      cache_rs2_q    <= divisor_q;
      cache_q_q      <= div_result_i[XLEN-1:0];
      cache_r_q      <= div_result_i[2*XLEN-1:XLEN];
    end else if (store_spec) begin
      cache_valid_q  <= 1'b1;
      cache_signed_q <= signed_q;
      cache_rs1_q    <= dividend_q;
      cache_rs2_q    <= divisor_q;
      cache_q_q      <= special_q_q;
      cache_r_q      <= special_r_q;
    end
  end
`else
  logic cache_hit;
  logic [XLEN-1:0] cache_q_q, cache_r_q;

  assign cache_hit = 1'b0;
  assign cache_q_q = '0;
  assign cache_r_q = '0;
`endif

  // Special-case results are decided at accept time and parked until SPECIAL.
  always_comb begin
    is_special = 1'b0;
    spec_q_d   = '1;
    spec_r_d   = rs1_i;
    if (cache_hit) begin
      is_special = 1'b1;
      spec_q_d   = cache_q_q;
      spec_r_d   = cache_r_q;
    end else if (rs2_i == '0) begin
      is_special = 1'b1;
      spec_q_d   = '1;
      spec_r_d   = rs1_i;
    end else if (op_signed && (rs1_i == MIN_NEG) && (rs2_i == '1)) begin
      is_special = 1'b1;
      spec_q_d   = MIN_NEG;
      spec_r_d   = '0;
    end
  end

  always_comb begin
    state_d        = state_q;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    div_start_o    = 1'b0;
    div_annul_o    = 1'b0;
    store_div      = 1'b0;
    store_spec     = 1'b0;
    result_now     = sel_rem_q ? special_r_q : special_q_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = is_special ? S_SPECIAL : S_WAIT;
        end
      end
      S_SPECIAL: begin
        if (flush_i) begin
          state_d = S_ABORT;
        end else begin
          result_valid_o = 1'b1;
          store_spec     = 1'b1;
          state_d        = S_IDLE;
        end
      end
      S_WAIT: begin
        div_start_o = 1'b1;
        if (flush_i) begin
          state_d = S_ABORT;
        end else if (div_ready_i) begin
          result_valid_o = 1'b1;
          store_div      = 1'b1;
          result_now     = sel_rem_q ? div_result_i[2*XLEN-1:XLEN] : div_result_i[XLEN-1:0];
          state_d        = S_RELEASE;
        end else begin
          stall_o = 1'b1;
        end
      end
      S_RELEASE: begin
        stall_o = op_valid_i;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        div_annul_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      sel_rem_q   <= 1'b0;
      signed_q    <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      special_q_q <= '0;
      special_r_q <= '0;
    end else if (accept) begin
      sel_rem_q   <= op_i[1];
      signed_q    <= op_signed;
      dividend_q  <= rs1_i;
      divisor_q   <= rs2_i;
      special_q_q <= spec_q_d;
      special_r_q <= spec_r_d;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      result_hold_q <= '0;
    end else if (result_valid_o) begin
      result_hold_q <= result_now;
    end
  end

  assign result_o       = result_valid_o ? result_now : result_hold_q;
  assign div_signed_o   = signed_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative-divider stub.
module tb_div_ctrl;

  localparam int LAT = 33;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        op_valid_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        result_valid_o;
  logic [31:0] result_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  div_ctrl #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .n_rst_i        (n_rst_i),
    .op_valid_i     (op_valid_i),
    .op_i           (op_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o),
    .div_start_o    (div_start_o),
    .div_annul_o    (div_annul_o),
    .div_signed_o   (div_signed_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_ready_i    (div_ready_i),
    .div_result_i   (div_result_i)
  );

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Divider stub: result after LAT cycles of start, ready held until start drops.
  logic busy;
  int   cnt;
  always @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      busy <= 1'b0; cnt <= 0; div_ready_i <= 1'b0; div_result_i <= '0;
    end else if (div_annul_o || !div_start_o) begin
      busy <= 1'b0; div_ready_i <= 1'b0;
    end else if (!busy) begin
      busy <= 1'b1; cnt <= LAT;
      div_result_i <= model_div(div_signed_o, div_dividend_o, div_divisor_o);
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else begin
      div_ready_i <= 1'b1;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic ok, output logic [31:0] res, output int lat,
                        output logic saw_start, output logic sgn, output logic acc_stall,
                        output logic post_start, output logic post_valid, output logic [31:0] post_res);
    ok = 1'b0; res = '0; lat = 0; saw_start = 1'b0; sgn = 1'b0;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    #1 acc_stall = stall_o;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      lat++;
      if (div_start_o && !saw_start) begin saw_start = 1'b1; sgn = div_signed_o; end
      if (result_valid_o) begin ok = 1'b1; res = result_o; break; end
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
    @(posedge clk_i); #1;
    post_start = div_start_o; post_valid = result_valid_o; post_res = result_o;
    @(negedge clk_i);
  endtask

  logic        ok, sst, sgn, acc, pst, pvl;
  logic [31:0] res, pres;
  int          lat;

  task automatic test_reset;
    n_rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({stall_o, result_valid_o, div_start_o, div_annul_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {stall_o, result_valid_o, div_start_o, div_annul_o});
    end
    checks++;
    if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    checks++;
    if ({div_signed_o, div_dividend_o, div_divisor_o} !== 65'd0) begin
      failures++; $display("FAIL reset_operands got=%b/%h/%h exp=0", div_signed_o, div_dividend_o, div_divisor_o);
    end
    n_rst_i = 1'b1;
  endtask

  task automatic test_unsigned;
    logic exp_start;
    run_op(2'b01, 32'd100, 32'd7, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL divu_timeout got=%b exp=1", ok); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_result got=%h exp=%h", res, 32'd14); end
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL divu_accept_stall got=%b exp=1", acc); end
    checks++; if (sst !== 1'b1) begin failures++; $display("FAIL divu_start got=%b exp=1", sst); end
    checks++; if (sgn !== 1'b0) begin failures++; $display("FAIL divu_signed got=%b exp=0", sgn); end
    checks++; if ({pst, pvl} !== 2'b00) begin failures++; $display("FAIL divu_release got=%b exp=00", {pst, pvl}); end
    checks++; if (pres !== 32'd14) begin failures++; $display("FAIL divu_hold got=%h exp=%h", pres, 32'd14); end
`ifdef DIV_CTRL_RESULT_CACHE_EN
    exp_start = 1'b0;
`else
    exp_start = 1'b1;
`endif
    run_op(2'b11, 32'd100, 32'd7, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL remu_result got=%h exp=%h", res, 32'd2); end
    checks++; if (sst !== exp_start) begin failures++; $display("FAIL remu_start got=%b exp=%b", sst, exp_start); end
    checks++; if ({pst, pvl} !== 2'b00) begin failures++; $display("FAIL remu_release got=%b exp=00", {pst, pvl}); end
  endtask

  task automatic test_signed;
    run_op(2'b00, 32'hFFFFFF9C, 32'd7, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'hFFFFFFF2) begin failures++; $display("FAIL div_neg_result got=%h exp=fffffff2", res); end
    checks++; if (sgn !== 1'b1) begin failures++; $display("FAIL div_neg_signed got=%b exp=1", sgn); end
    run_op(2'b10, 32'hFFFFFF9C, 32'd7, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'hFFFFFFFE) begin failures++; $display("FAIL rem_neg_result got=%h exp=fffffffe", res); end
  endtask

  task automatic test_div_by_zero;
    run_op(2'b00, 32'd5, 32'd0, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL divz_result got=%h exp=ffffffff", res); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL divz_latency got=%0d exp=1", lat); end
    checks++; if ({sst, pst} !== 2'b00) begin failures++; $display("FAIL divz_start got=%b exp=00", {sst, pst}); end
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL divz_accept_stall got=%b exp=1", acc); end
    run_op(2'b11, 32'd5, 32'd0, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'd5) begin failures++; $display("FAIL remuz_result got=%h exp=5", res); end
    checks++; if ({lat == 1, sst} !== 2'b10) begin failures++; $display("FAIL remuz_path lat=%0d start=%b exp lat=1 start=0", lat, sst); end
  endtask

  task automatic test_overflow;
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'h80000000) begin failures++; $display("FAIL ovf_div_result got=%h exp=80000000", res); end
    checks++; if ({lat == 1, sst} !== 2'b10) begin failures++; $display("FAIL ovf_div_path lat=%0d start=%b exp lat=1 start=0", lat, sst); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'd0) begin failures++; $display("FAIL ovf_rem_result got=%h exp=0", res); end
    // Same operands unsigned are an ordinary divide.
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if ({res, sst} !== {32'd0, 1'b1}) begin failures++; $display("FAIL ovf_divu got=%h start=%b exp=0 start=1", res, sst); end
  endtask

  task automatic test_flush;
    logic any_valid;
    int   annul_cnt;
    any_valid = 1'b0; annul_cnt = 0;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd1000; rs2_i = 32'd3;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (result_valid_o) any_valid = 1'b1;
    end
    checks++;
    if ({div_start_o, stall_o, div_signed_o, div_dividend_o, div_divisor_o} !== {3'b111, 32'd1000, 32'd3}) begin
      failures++; $display("FAIL flush_wait_outputs got=%b%b%b %h %h exp=111 000003e8 00000003",
                           div_start_o, stall_o, div_signed_o, div_dividend_o, div_divisor_o);
    end
    @(negedge clk_i);
    flush_i = 1'b1; op_valid_i = 1'b0;
    #1 if (result_valid_o) any_valid = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({div_annul_o, div_start_o, stall_o} !== 3'b100) begin
      failures++; $display("FAIL flush_abort got=%b exp=100", {div_annul_o, div_start_o, stall_o});
    end
    for (int i = 0; i < 5; i++) begin
      if (div_annul_o) annul_cnt++;
      if (result_valid_o) any_valid = 1'b1;
      @(negedge clk_i); flush_i = 1'b0;
      @(posedge clk_i); #1;
    end
    checks++; if (annul_cnt !== 1) begin failures++; $display("FAIL flush_annul_pulses got=%0d exp=1", annul_cnt); end
    checks++; if (any_valid !== 1'b0) begin failures++; $display("FAIL flush_no_result got=%b exp=0", any_valid); end
    run_op(2'b01, 32'd9, 32'd3, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if ({ok, res, sst} !== {1'b1, 32'd3, 1'b1}) begin failures++; $display("FAIL flush_next_op got=%b %h %b exp=1 3 1", ok, res, sst); end
  endtask

  task automatic test_cache;
    logic exp_fast;
`ifdef DIV_CTRL_RESULT_CACHE_EN
    exp_fast = 1'b1;
`else
    exp_fast = 1'b0;
`endif
    run_op(2'b00, 32'd50, 32'd6, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if ({res, sst} !== {32'd8, 1'b1}) begin failures++; $display("FAIL cache_div got=%h start=%b exp=8 start=1", res, sst); end
    run_op(2'b10, 32'd50, 32'd6, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL cache_rem_result got=%h exp=2", res); end
    checks++; if ({lat == 1, !sst} !== {exp_fast, exp_fast}) begin failures++; $display("FAIL cache_rem_path lat=%0d start=%b fast_exp=%b", lat, sst, exp_fast); end
    // Flush presented in IDLE: no accept, and any cached entry is dropped.
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = 2'b10; rs1_i = 32'd50; rs2_i = 32'd6; flush_i = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL idle_flush_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    checks++;
    if ({div_start_o, result_valid_o, div_annul_o, stall_o} !== 4'b0000) begin
      failures++; $display("FAIL idle_flush_no_accept got=%b exp=0000", {div_start_o, result_valid_o, div_annul_o, stall_o});
    end
    @(negedge clk_i); flush_i = 1'b0; op_valid_i = 1'b0;
    run_op(2'b10, 32'd50, 32'd6, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if ({res, sst} !== {32'd2, 1'b1}) begin failures++; $display("FAIL cache_after_flush got=%h start=%b exp=2 start=1", res, sst); end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk_i);
    op_valid_i = 1'b1; op_i = 2'b00; rs1_i = 32'd1000; rs2_i = 32'd3;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    n_rst_i = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, result_valid_o, div_start_o, div_annul_o, div_signed_o, div_dividend_o, div_divisor_o, result_o} !== 101'd0) begin
      failures++; $display("FAIL mid_reset_outputs got=%b%b%b%b%b %h %h %h exp=all zero", stall_o, result_valid_o,
                           div_start_o, div_annul_o, div_signed_o, div_dividend_o, div_divisor_o, result_o);
    end
    @(negedge clk_i); n_rst_i = 1'b1;
    run_op(2'b01, 32'd9, 32'd3, ok, res, lat, sst, sgn, acc, pst, pvl, pres);
    checks++; if ({ok, res} !== {1'b1, 32'd3}) begin failures++; $display("FAIL mid_reset_recover got=%b %h exp=1 3", ok, res); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_flush();
    test_cache();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer between the EX stage and the iterative 32-bit divider.
- Decodes RISC-V M-extension divide ops (DIV/DIVU/REM/REMU) and resolves the divide-by-zero and signed-overflow corner cases locally, with 1-cycle latency and no divider start.
- For all other operands: drives the divider start/annul handshake, stalls EX, selects quotient or remainder, and releases the divider back to its free state.

Parameters:
- XLEN, 32, operand and result width; the divider is fixed at 32, so only 32 is legal.

Ports:
- clk_i  in  1  clock
- n_rst_i  in  1  asynchronous active-low reset
- op_valid_i  in  1  EX presents a divide op; held while stall_o=1
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_i  in  32  dividend
- rs2_i  in  32  divisor
- flush_i  in  1  pipeline flush (exception/interrupt); abandons the current op
- stall_o  out  1  hold EX
- result_valid_o  out  1  one-cycle pulse; result_o is valid
- result_o  out  32  quotient or remainder
- div_start_o  out  1  to divider start
- div_annul_o  out  1  to divider annul
- div_signed_o  out  1  to divider signed select
- div_dividend_o  out  32  registered operand to divider
- div_divisor_o  out  32  registered operand to divider
- div_ready_i  in  1  from divider ready
- div_result_i  in  64  from divider: [31:0] quotient, [63:32] remainder

Behaviour:
- Reset (async, n_rst_i=0): state IDLE. All outputs 0; operand registers 0.
- States: IDLE, SPECIAL, WAIT, RELEASE, ABORT.
- IDLE, op_valid_i=1, flush_i=0: accept the op; latch op, rs1 and rs2. stall_o=1 combinationally in the accept cycle.
  - rs2==0 -> SPECIAL with Q=32'hFFFFFFFF, R=rs1. Applies to both signed and unsigned ops.
  - Signed op with rs1==32'h80000000 and rs2==32'hFFFFFFFF -> SPECIAL with Q=32'h80000000, R=0.
  - Otherwise -> WAIT. Next cycle: div_start_o=1, div_signed_o=~op[0], div_dividend_o/div_divisor_o driven from the latched operands.
- SPECIAL: result_valid_o=1 and stall_o=0 for one cycle. result_o = op[1] ? R : Q. Then IDLE. The divider is never started.
- WAIT:
  - div_start_o is held 1.
  - On div_ready_i=1: result_o = op[1] ? div_result_i[63:32] : div_result_i[31:0]; result_valid_o=1; stall_o=0 in the same cycle; next state RELEASE.
  - Latency with the current divider: 36 cycles from accept to result_valid_o. The bench checks the handshake only, not the count.
- RELEASE: div_start_o=0 for exactly one cycle, so the divider leaves its end state. stall_o = op_valid_i. A new op is not accepted here. Next state IDLE.
- flush_i=1:
  - In WAIT or SPECIAL, flush overrides any ready. result_valid_o=0; next state ABORT.
  - ABORT is one cycle: div_start_o=0, div_annul_o=1, stall_o=0. Then IDLE.
  - In IDLE, flush_i blocks acceptance.
- div_annul_o=1 only in ABORT.
- result_valid_o is never high on two consecutive cycles.
- result_o holds its last value when result_valid_o=0.
- div_ready_i outside WAIT is ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The divider is reset by the same reset.

Optional Feature:
- Macro DIV_CTRL_RESULT_CACHE_EN.
- Defined:
  - Store {valid, signed, rs1, rs2, Q, R} on every completed non-flushed divide or special case.
  - An accepted op with matching signedness and operands and valid=1 goes to SPECIAL using the cached Q/R, so a DIV+REM pair costs one divider run.
  - Cache valid clears on reset and on flush_i.
- Undefined: no cache logic; every regular op goes to WAIT.

Test Plan:
- DIVU rs1=100, rs2=7 -> result_valid_o pulse with result_o=14; a following REMU with the same operands -> 2. Check div_start_o drops for one cycle after each ready.
- DIV rs1=-100 (32'hFFFFFF9C), rs2=7 -> result_o=32'hFFFFFFF2; REM with the same operands -> 32'hFFFFFFFE.
- DIV rs1=5, rs2=0 -> result_o=32'hFFFFFFFF one cycle after accept, div_start_o never 1; REMU rs1=5, rs2=0 -> 5.
- DIV rs1=32'h80000000, rs2=32'hFFFFFFFF -> result_o=32'h80000000 with 1-cycle latency; REM with the same operands -> 0.
- DIV 1000/3 with flush_i asserted 10 cycles after accept -> no result_valid_o; div_annul_o=1 for exactly one cycle; next op DIVU 9/3 -> 3.
- With DIV_CTRL_RESULT_CACHE_EN: DIV 50/6 then REM 50/6 -> second result 2 with 1-cycle latency and no div_start_o. Without the macro, the second op restarts the divider.
